// File: rtl/hilo_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// hilo_div_unit_pkg
// Shared definitions for the HI/LO divide unit.
//   state_t       : FSM state encoding (IDLE, CALC, FIXUP)
//   DEFAULT_WIDTH : default operand / quotient / remainder width
//   INT_MIN       : most negative 32-bit value; div INT_MIN / -1 wraps back
//                   to INT_MIN with a zero remainder
// -----------------------------------------------------------------------------
package hilo_div_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

endpackage : hilo_div_unit_pkg

// File: rtl/hilo_div_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_div_unit_if
// Execute-stage connection between the ALU side and the divide / HI-LO unit.
//   start, is_signed, a, b        : issue a div (is_signed=1) or divu
//   write_hi, write_lo, write_data : mthi / mtlo
//   busy                           : divide in flight (feeds the hazard unit)
//   done, div_zero                 : completion pulse and zero-divisor flag
//   hi, lo                         : remainder / quotient (or mthi/mtlo data)
// master = ALU side, slave = divide unit.
// -----------------------------------------------------------------------------
interface hilo_div_unit_if
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             write_hi;
    logic             write_lo;
    logic [WIDTH-1:0] write_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b, write_hi, write_lo, write_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b, write_hi, write_lo, write_data,
        output busy, done, div_zero, hi, lo
    );

endinterface : hilo_div_unit_if

// File: rtl/hilo_div_unit_div_step.sv
// -----------------------------------------------------------------------------
// hilo_div_unit_div_step
// One combinational radix-2 restoring division iteration.
//   rem_in, quot_in : partial remainder and quotient/dividend shift register
//   divisor         : divisor magnitude
//   rem_out, quot_out : values after shifting in one dividend bit and
//                       appending one quotient bit
// -----------------------------------------------------------------------------
module hilo_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;

    // The partial remainder always stays below the divisor, so the shifted
    // remainder is below 2*divisor and one extra bit is enough to see the
    // sign of the trial subtraction.
    assign rem_shift = {rem_in, quot_in[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor};

    always_comb begin
        if (!trial[WIDTH]) begin
            rem_out  = trial[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out  = rem_shift[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule : hilo_div_unit_div_step

// File: rtl/hilo_div_unit.sv
// -----------------------------------------------------------------------------
// hilo_div_unit
// Multi-cycle divide unit plus HI/LO register pair for the execute stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards any divide in flight
//   bus   : slave side of hilo_div_unit_if (start/operands, mthi/mtlo,
//           busy/done/div_zero status, hi/lo registers)
// Timing: start sampled at edge 0, WIDTH CALC iterations, two FIXUP edges
// (sign correction, then commit), so hi/lo change on edge WIDTH+2 and done
// is high for the cycle after it.
// -----------------------------------------------------------------------------
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    hilo_div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg,     state_next;
    logic [CW-1:0]    count_reg,     count_next;
    logic [WIDTH-1:0] rem_reg,       rem_next;
    logic [WIDTH-1:0] quot_reg,      quot_next;
    logic [WIDTH-1:0] divisor_reg,   divisor_next;
    logic [WIDTH-1:0] dividend_reg,  dividend_next;
    logic             q_neg_reg,     q_neg_next;
    logic             r_neg_reg,     r_neg_next;
    logic             fix_phase_reg, fix_phase_next;
    logic [WIDTH-1:0] hi_reg,        hi_next;
    logic [WIDTH-1:0] lo_reg,        lo_next;
    logic             done_reg,      done_next;
    logic             div_zero_reg,  div_zero_next;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quot;
    logic             divisor_zero;

    // Operand signs only matter for div; divu treats the MSB as magnitude.
    assign a_neg = bus.is_signed & bus.a[WIDTH-1];
    assign b_neg = bus.is_signed & bus.b[WIDTH-1];
    assign a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;

    assign divisor_zero = (divisor_reg == '0);

    hilo_div_unit_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in   (rem_reg),
        .quot_in  (quot_reg),
        .divisor  (divisor_reg),
        .rem_out  (step_rem),
        .quot_out (step_quot)
    );

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            divisor_reg   <= '0;
            dividend_reg  <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            fix_phase_reg <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            done_reg      <= 1'b0;
            div_zero_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rem_reg       <= rem_next;
            quot_reg      <= quot_next;
            divisor_reg   <= divisor_next;
            dividend_reg  <= dividend_next;
            q_neg_reg     <= q_neg_next;
            r_neg_reg     <= r_neg_next;
            fix_phase_reg <= fix_phase_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            done_reg      <= done_next;
            div_zero_reg  <= div_zero_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        rem_next       = rem_reg;
        quot_next      = quot_reg;
        divisor_next   = divisor_reg;
        dividend_next  = dividend_reg;
        q_neg_next     = q_neg_reg;
        r_neg_next     = r_neg_reg;
        fix_phase_next = fix_phase_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        done_next      = 1'b0;
        div_zero_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    // Start takes priority; mthi/mtlo in the same cycle are dropped.
                    rem_next       = '0;
                    quot_next      = a_mag;
                    divisor_next   = b_mag;
                    dividend_next  = bus.a;
                    q_neg_next     = a_neg ^ b_neg;
                    r_neg_next     = a_neg;
                    count_next     = CW'(WIDTH - 1);
                    fix_phase_next = 1'b0;
                    state_next     = ST_CALC;
                end else begin
                    if (bus.write_hi) begin
                        hi_next = bus.write_data;
                    end
                    if (bus.write_lo) begin
                        lo_next = bus.write_data;
                    end
                end
            end

            ST_CALC: begin
                rem_next   = step_rem;
                quot_next  = step_quot;
                count_next = count_reg - CW'(1);
                if (count_reg == '0) begin
                    state_next     = ST_FIXUP;
                    fix_phase_next = 1'b0;
                end
            end

            ST_FIXUP: begin
                if (!fix_phase_reg) begin
                    // First edge: sign-correct in place so the commit edge is
                    // a plain register copy.
                    if (divisor_zero) begin
                        quot_next = '1;
                        rem_next  = dividend_reg;
                    end else begin
                        quot_next = q_neg_reg ? (~quot_reg + 1'b1) : quot_reg;
                        rem_next  = r_neg_reg ? (~rem_reg + 1'b1) : rem_reg;
                    end
                    fix_phase_next = 1'b1;
                end else begin
                    hi_next        = rem_reg;
                    lo_next        = quot_reg;
                    done_next      = 1'b1;
                    div_zero_next  = divisor_zero;
                    fix_phase_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;

endmodule : hilo_div_unit

// File: tb/tb_hilo_div_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_unit
// Directed self-checking bench for hilo_div_unit with a result scoreboard.
// -----------------------------------------------------------------------------
module tb_hilo_div_unit;
    import hilo_div_unit_pkg::*;

    localparam int W       = 32;
    localparam int LATENCY = W + 2;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   edge_cnt;
    int   start_edge;
    exp_t sb[$];

    hilo_div_unit_if #(.WIDTH(W)) bus ();

    hilo_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: truncating division, zero divisor gives all-ones / A.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        exp_t e;
        e.dz = (b == '0);
        if (b == '0) begin
            e.lo = '1;
            e.hi = a;
        end else if (sgn && a == INT_MIN && b == '1) begin
            e.lo = INT_MIN;
            e.hi = '0;
        end else if (sgn) begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Drive a start for one edge (optionally with an mtlo), push the expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                         input logic with_wlo);
        exp_t e;
        logic [W-1:0] lo_before;
        e.hi = ehi; e.lo = elo; e.dz = edz;
        sb.push_back(e);
        lo_before = bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = sgn; bus.a = a; bus.b = b;
        bus.write_lo = with_wlo; bus.write_data = 32'h7777_7777;
        @(posedge clk);
        #1;
        start_edge = edge_cnt;
        bus.start = 1'b0; bus.write_lo = 1'b0;
        check("busy_after_start", {31'b0, bus.busy}, 32'd1);
        if (with_wlo) check("lo_start_wins_write", bus.lo, lo_before);
        $display("[TB] issue a=%h b=%h signed=%0b", a, b, sgn);
    endtask

    // Wait (bounded) for done, then pop and compare against the scoreboard.
    task automatic wait_result(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        e = sb.pop_front();
        if (seen) begin
            check({tag, "_latency"}, W'(edge_cnt - start_edge), W'(LATENCY));
            check({tag, "_lo"}, bus.lo, e.lo);
            check({tag, "_hi"}, bus.hi, e.hi);
            check({tag, "_divzero"}, {31'b0, bus.div_zero}, {31'b0, e.dz});
            check({tag, "_busy_low"}, {31'b0, bus.busy}, 32'd0);
            $display("[TB] result %s hi=%h lo=%h divzero=%0b", tag, bus.hi, bus.lo, bus.div_zero);
            @(posedge clk);
            #1;
            check({tag, "_done_single"}, {31'b0, bus.done}, 32'd0);
        end
    endtask

    // Count done pulses over a window where none are expected.
    task automatic expect_no_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) n++;
        end
        check(tag, W'(n), 32'd0);
    endtask

    task automatic write_regs(input logic whi, input logic wlo, input logic [W-1:0] data);
        @(negedge clk);
        bus.write_hi = whi; bus.write_lo = wlo; bus.write_data = data;
        @(posedge clk);
        #1;
        bus.write_hi = 1'b0; bus.write_lo = 1'b0;
        $display("[TB] write hi=%0b lo=%0b data=%h", whi, wlo, data);
    endtask

    initial begin
        exp_t m;
        logic [W-1:0] ra, rb;
        logic         rs;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
        bus.write_hi = 1'b0; bus.write_lo = 1'b0; bus.write_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_divzero", {31'b0, bus.div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'd6, 32'd3, 1'b0, 32'd0, 32'd2, 1'b0, 1'b0);
        wait_result("divu_6_3");
        issue(32'd1, 32'd3, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0);
        wait_result("divu_1_3");
        issue(32'd11, 32'd3, 1'b0, 32'd2, 32'd3, 1'b0, 1'b0);
        wait_result("divu_11_3");
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        wait_result("div_m7_2");
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        wait_result("div_7_m2");
        issue(32'd10, 32'd0, 1'b0, 32'd10, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_result("divu_10_0");
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_result("div_m5_0");
        issue(INT_MIN, 32'hFFFF_FFFF, 1'b1, 32'd0, INT_MIN, 1'b0, 1'b0);
        wait_result("div_overflow");

        // Reset in the middle of a divide discards it.
        issue(32'd10, 32'd3, 1'b1, 32'd1, 32'd3, 1'b0, 1'b0);
        void'(sb.pop_back());
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_hi", bus.hi, '0);
        check("midrst_lo", bus.lo, '0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_done("midrst_no_done", 40);
        issue(32'd11, 32'd3, 1'b0, 32'd2, 32'd3, 1'b0, 1'b0);
        wait_result("after_rst_11_3");

        // mthi / mtlo in IDLE.
        write_regs(1'b1, 1'b0, 32'h0000_1234);
        check("mthi_hi", bus.hi, 32'h0000_1234);
        check("mthi_lo_kept", bus.lo, 32'd3);
        write_regs(1'b0, 1'b1, 32'h0000_5678);
        check("mtlo_lo", bus.lo, 32'h0000_5678);
        write_regs(1'b1, 1'b1, 32'h0000_ABCD);
        check("mthilo_hi", bus.hi, 32'h0000_ABCD);
        check("mthilo_lo", bus.lo, 32'h0000_ABCD);

        // mtlo while busy is ignored.
        issue(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 1'b0);
        write_regs(1'b0, 1'b1, 32'h0000_DEAD);
        check("busy_mtlo_ignored", bus.lo, 32'h0000_ABCD);
        wait_result("divu_100_7");

        // Start together with mtlo: the divide wins.
        issue(32'd50, 32'd6, 1'b0, 32'd2, 32'd8, 1'b0, 1'b1);
        wait_result("start_with_mtlo");

        // Second start while busy has no effect.
        issue(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd9; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_result("second_start_ignored");
        expect_no_done("second_start_no_extra", 40);

        // A few random operands against the reference model.
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = $urandom_range(1, 65535);
            rs = 1'(k[0]);
            if (k == 3) rb = -rb;
            m = model(ra, rb, rs);
            issue(ra, rb, rs, m.hi, m.lo, m.dz, 1'b0);
            wait_result("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_hilo_div_unit

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle divide unit plus HI/LO register pair for the mips32 execute stage.
- Sits directly beside the ALU. The ALU issues div/divu, mthi and mtlo into it, and reads Hi/Lo for mfhi/mflo.
- Busy drives the hazard unit so the pipeline stalls mfhi/mflo and a second div while a divide is in flight.
- Radix-2 restoring divider, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin a divide with A and B this cycle.
- Signed  in  1  1 = div (two's complement), 0 = divu; sampled with Start.
- A  in  WIDTH  dividend.
- B  in  WIDTH  divisor.
- WriteHi  in  1  mthi: load Hi from WriteData.
- WriteLo  in  1  mtlo: load Lo from WriteData.
- WriteData  in  WIDTH  data for mthi/mtlo.
- Busy  out  1  divide in progress.
- Done  out  1  one-cycle pulse: Hi/Lo were just updated by a divide.
- DivZero  out  1  valid with Done: divisor was zero.
- Hi  out  WIDTH  remainder / mthi value.
- Lo  out  WIDTH  quotient / mtlo value.

Behaviour:
- Reset (Reset=0, any time, including mid-divide):
  - State=IDLE.
  - Hi=0, Lo=0, Busy=0, Done=0, DivZero=0.
  - Internal remainder, quotient and count cleared.
  - The in-flight divide is discarded.
- States: IDLE, CALC, FIXUP.
  - Busy = (state != IDLE), decoded from registered state.
- IDLE:
  - Start=1 at an edge latches |A|, |B| (magnitudes if Signed, raw values otherwise), the quotient sign (A sign XOR B sign) and the remainder sign (A sign). Next state is CALC with count=WIDTH-1.
- CALC, one iteration per edge:
  - Shift {rem, quot} left 1.
  - Trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial and quot LSB = 1. Otherwise rem is kept and quot LSB = 0.
  - After WIDTH iterations (count reaches 0), go to FIXUP.
- FIXUP:
  - Lo = quot, negated if Signed and the quotient sign is negative.
  - Hi = rem, negated if Signed and the remainder sign is negative (truncating division; remainder takes the dividend's sign).
  - Next state IDLE. Done=1 and DivZero registered for exactly the following cycle.
- Latency:
  - Start sampled at edge 0.
  - Hi/Lo hold new values after edge WIDTH+2 (34 edges for WIDTH=32).
  - Busy high from after edge 0 through edge WIDTH+2.
  - Done high during the cycle after edge WIDTH+2.
- Divisor zero:
  - Same latency, no exception.
  - Result Lo = all ones and Hi = A, for both div and divu (forced in FIXUP).
  - DivZero=1 with Done.
- Signed overflow: A = 0x80000000, B = 0xFFFFFFFF, Signed=1 gives Lo=0x80000000, Hi=0, DivZero=0.
- Start while Busy: ignored; the current divide continues.
- WriteHi/WriteLo:
  - Honoured only in IDLE, updating on that edge.
  - Ignored while Busy; the hazard unit guarantees they do not occur then.
- Start with WriteHi/WriteLo in the same IDLE cycle: Start wins and the writes are dropped.
- WriteHi and WriteLo together: both registers load WriteData.
- Hi/Lo hold their values between updates; outputs are driven directly from registers.

Decomposition:
- Shared package holds:
  - state encodings (IDLE, CALC, FIXUP), a 2-bit state type;
  - WIDTH default;
  - the constant 0x80000000 used for the overflow case.
  - Funct_Div/Funct_Divu/Funct_Mthi/Funct_Mtlo already live in the opcode/funct parameter include.
- One natural sub-module: div_step. It is combinational: it takes rem, quot and divisor, and returns the next rem and quot for one restoring iteration.
- The FSM, sign fixup and HI/LO registers stay in hilo_div_unit.

Test Plan:
- divu A=6, B=3 → after 34 edges: Lo=2, Hi=0, Done pulses once, Busy low afterwards.
- divu A=1, B=3 → Lo=0, Hi=1. Then divu A=11, B=3 → Lo=3, Hi=2.
- div A=-7 (0xFFFFFFF9), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then div A=7, B=-2 → Lo=0xFFFFFFFD, Hi=1.
- divu A=10, B=0 → Lo=0xFFFFFFFF, Hi=10, DivZero=1 with Done. div 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0, DivZero=0.
- Start div 10/3, pulse Reset low at edge 5 → Hi=Lo=0, Busy=0, no Done. Then divu 11/3 completes with Hi=2, Lo=3.
- In IDLE:
  - WriteHi with WriteData=0x1234 → Hi=0x1234.
  - WriteLo during Busy → ignored.
  - Start plus WriteLo in the same cycle → divide result wins.
  - Second Start during Busy → no effect on the result.
